// File: rtl/prga_if.sv
// prga_if: start handshake plus the S, CT and PT memory ports of the RC4
// keystream/decrypt stage.
// The slave modport is the prga stage itself. The master modport is the
// controller/memory side, which drives en and the two read-data buses.
interface prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;
  logic       pt_valid;

  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata,
           pt_wren, pt_valid
  );

  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata,
           pt_wren, pt_valid
  );
endinterface

// File: rtl/prga.sv
// prga: RC4 pseudo-random generation and decrypt stage.
// It runs after key scheduling has permuted the shared 256-byte S memory.
// It reads a length-prefixed ciphertext from CT memory and keeps permuting S
// through a single S port. It writes the length-prefixed plaintext to PT.
// Effective length E = min(ct[0], MAX_LEN).
// A run takes 3 + 9*E cycles from leaving READY until READY again.
//
// Optional feature, macro PRGA_ASCII_CHECK_EN:
//   When defined, pt_valid is cleared for the rest of a run once any
//   plaintext byte falls outside 0x20..0x7E. The flag is set again at each start.
//   When undefined, pt_valid is tied to 1.
module prga #(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic  clk,
  input  logic  rst_n,
  prga_if.slave bus
);

  // A length byte can never exceed 255, so larger settings behave as 255.
  localparam int unsigned MAX_CLAMP = (MAX_LEN > 255) ? 255 : MAX_LEN;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_CLAMP);

  typedef enum logic [3:0] {
    READY   = 4'd0,
    RD_LEN  = 4'd1,
    CAP_LEN = 4'd2,
    WR_LEN  = 4'd3,
    RD_I    = 4'd4,
    CAP_I   = 4'd5,
    RD_J    = 4'd6,
    CAP_J   = 4'd7,
    WR_I    = 4'd8,
    WR_J    = 4'd9,
    RD_PAD  = 4'd10,
    CAP_PAD = 4'd11,
    WR_PT   = 4'd12
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] i_reg, i_next;
  logic [7:0] j_reg, j_next;
  logic [7:0] k_reg, k_next;
  logic [7:0] e_reg, e_next;
  logic [7:0] si_reg, si_next;
  logic [7:0] sj_reg, sj_next;
  logic [7:0] pad_reg, pad_next;
  logic [7:0] ctb_reg, ctb_next;

  // Decoded output values, driven onto the interface below.
  logic       rdy_c;
  logic [7:0] s_addr_c;
  logic [7:0] s_wrdata_c;
  logic       s_wren_c;
  logic [7:0] ct_addr_c;
  logic [7:0] pt_addr_c;
  logic [7:0] pt_wrdata_c;
  logic       pt_wren_c;

  // Plaintext byte for the current position; S holds the updated swap by now.
  logic [7:0] pt_byte;
  assign pt_byte = pad_reg ^ ctb_reg;

  // State and datapath registers. Reset drops any run in progress at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= READY;
      i_reg     <= 8'd0;
      j_reg     <= 8'd0;
      k_reg     <= 8'd0;
      e_reg     <= 8'd0;
      si_reg    <= 8'd0;
      sj_reg    <= 8'd0;
      pad_reg   <= 8'd0;
      ctb_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      e_reg     <= e_next;
      si_reg    <= si_next;
      sj_reg    <= sj_next;
      pad_reg   <= pad_next;
      ctb_reg   <= ctb_next;
    end
  end

  // Next-state logic and datapath captures: one S access per cycle, 9 cycles per byte.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    e_next     = e_reg;
    si_next    = si_reg;
    sj_next    = sj_reg;
    pad_next   = pad_reg;
    ctb_next   = ctb_reg;

    case (state_reg)
      READY: begin
        if (bus.en) begin
          i_next     = 8'd0;
          j_next     = 8'd0;
          k_next     = 8'd0;
          state_next = RD_LEN;
        end
      end
      RD_LEN:  state_next = CAP_LEN;
      CAP_LEN: begin
        e_next     = (bus.ct_rddata > MAX_LEN_B) ? MAX_LEN_B : bus.ct_rddata;
        state_next = WR_LEN;
      end
      WR_LEN: begin
        if (e_reg == 8'd0) begin
          state_next = READY;
        end else begin
          k_next     = 8'd1;
          i_next     = 8'd1;
          state_next = RD_I;
        end
      end
      RD_I:  state_next = CAP_I;
      CAP_I: begin
        si_next    = bus.s_rddata;
        j_next     = j_reg + bus.s_rddata;
        state_next = RD_J;
      end
      RD_J:  state_next = CAP_J;
      CAP_J: begin
        sj_next    = bus.s_rddata;
        state_next = WR_I;
      end
      WR_I:  state_next = WR_J;
      WR_J:  state_next = RD_PAD;
      RD_PAD: begin
        // CT address has been held since WR_J, so ct[k] is on the bus now.
        ctb_next   = bus.ct_rddata;
        state_next = CAP_PAD;
      end
      CAP_PAD: begin
        pad_next   = bus.s_rddata;
        state_next = WR_PT;
      end
      WR_PT: begin
        if (k_reg == e_reg) begin
          state_next = READY;
        end else begin
          k_next     = k_reg + 8'd1;
          i_next     = i_reg + 8'd1;
          state_next = RD_I;
        end
      end
      default: state_next = READY;
    endcase
  end

  // Output decode from the current state; idle values everywhere else.
  always_comb begin
    rdy_c       = 1'b0;
    s_addr_c    = 8'd0;
    s_wrdata_c  = 8'd0;
    s_wren_c    = 1'b0;
    ct_addr_c   = 8'd0;
    pt_addr_c   = 8'd0;
    pt_wrdata_c = 8'd0;
    pt_wren_c   = 1'b0;

    case (state_reg)
      READY:  rdy_c = 1'b1;
      RD_LEN: ct_addr_c = 8'd0;
      WR_LEN: begin
        pt_addr_c   = 8'd0;
        pt_wrdata_c = e_reg;
        pt_wren_c   = 1'b1;
      end
      RD_I: s_addr_c = i_reg;
      RD_J: s_addr_c = j_reg;
      WR_I: begin
        s_addr_c   = i_reg;
        s_wrdata_c = sj_reg;
        s_wren_c   = 1'b1;
      end
      WR_J: begin
        // When i == j both writes hit one address with equal data, which is correct.
        s_addr_c   = j_reg;
        s_wrdata_c = si_reg;
        s_wren_c   = 1'b1;
        ct_addr_c  = k_reg;
      end
      RD_PAD: begin
        s_addr_c  = si_reg + sj_reg;
        ct_addr_c = k_reg;
      end
      WR_PT: begin
        pt_addr_c   = k_reg;
        pt_wrdata_c = pt_byte;
        pt_wren_c   = 1'b1;
      end
      default: rdy_c = 1'b0;
    endcase
  end

  assign bus.rdy       = rdy_c;
  assign bus.s_addr    = s_addr_c;
  assign bus.s_wrdata  = s_wrdata_c;
  assign bus.s_wren    = s_wren_c;
  assign bus.ct_addr   = ct_addr_c;
  assign bus.pt_addr   = pt_addr_c;
  assign bus.pt_wrdata = pt_wrdata_c;
  assign bus.pt_wren   = pt_wren_c;

`ifdef PRGA_ASCII_CHECK_EN
  logic pt_valid_reg;
  logic printable;
  assign printable = (pt_byte >= 8'h20) && (pt_byte <= 8'h7E);

  // Printable flag: set on each start, cleared by any non-printable byte, held in READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_valid_reg <= 1'b1;
    end else if (state_reg == READY && bus.en) begin
      pt_valid_reg <= 1'b1;
    end else if (state_reg == WR_PT && !printable) begin
      pt_valid_reg <= 1'b0;
    end
  end

  assign bus.pt_valid = pt_valid_reg;
`else
  assign bus.pt_valid = 1'b1;
`endif

endmodule

// File: tb/tb_prga.sv
// tb_prga: checks the RC4 keystream stage against a plain RC4 reference model.
// Directed table vectors, randomized permutations/ciphertexts, handshake,
// mid-run reset and a MAX_LEN=2 instance.
module tb_prga;
  localparam int LIMIT = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prga_if bus ();
  prga_if bus_b ();

  prga #(.MAX_LEN(255)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  prga #(.MAX_LEN(2))   dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Memory models (synchronous read, one-cycle latency)
  logic [7:0] img_s    [256];
  logic [7:0] ct_mem   [256];
  logic [7:0] s_mem    [256];
  logic [7:0] pt_mem   [256];
  logic [7:0] s_mem_b  [256];
  logic [7:0] pt_mem_b [256];
  logic [7:0] s_q, ct_q, s_q_b, ct_q_b;
  logic       mem_load = 1'b0;
  int         s_wr_cnt = 0;
  int         pt_wr_cnt = 0;
  int         pt_wr_cnt_b = 0;

  assign bus.s_rddata    = s_q;
  assign bus.ct_rddata   = ct_q;
  assign bus_b.s_rddata  = s_q_b;
  assign bus_b.ct_rddata = ct_q_b;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int a = 0; a < 256; a++) begin
        s_mem[a]    <= img_s[a];
        s_mem_b[a]  <= img_s[a];
        pt_mem[a]   <= 8'hEE;
        pt_mem_b[a] <= 8'hEE;
      end
      s_wr_cnt    <= 0;
      pt_wr_cnt   <= 0;
      pt_wr_cnt_b <= 0;
    end else begin
      if (bus.s_wren) begin
        s_mem[bus.s_addr] <= bus.s_wrdata;
        s_wr_cnt <= s_wr_cnt + 1;
      end
      if (bus.pt_wren) begin
        pt_mem[bus.pt_addr] <= bus.pt_wrdata;
        pt_wr_cnt <= pt_wr_cnt + 1;
      end
      if (bus_b.s_wren) s_mem_b[bus_b.s_addr] <= bus_b.s_wrdata;
      if (bus_b.pt_wren) begin
        pt_mem_b[bus_b.pt_addr] <= bus_b.pt_wrdata;
        pt_wr_cnt_b <= pt_wr_cnt_b + 1;
      end
    end
    s_q    <= s_mem[bus.s_addr];
    ct_q   <= ct_mem[bus.ct_addr];
    s_q_b  <= s_mem_b[bus_b.s_addr];
    ct_q_b <= ct_mem[bus_b.ct_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: textbook RC4 output loop over plain arrays
  int m_s [256];
  int m_pt[256];
  bit m_valid;
  int m_cyc, m_swr;

  task automatic model_run(input int maxlen);
    int e, i, j, t, pad, b;
    for (int a = 0; a < 256; a++) begin
      m_s[a]  = int'(img_s[a]);
      m_pt[a] = 'hEE;
    end
    e = (int'(ct_mem[0]) > maxlen) ? maxlen : int'(ct_mem[0]);
    m_pt[0] = e;
    m_valid = 1'b1;
    i = 0;
    j = 0;
    for (int n = 1; n <= e; n++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      pad = m_s[(m_s[i] + m_s[j]) % 256];
      b = int'(ct_mem[n]) ^ pad;
      m_pt[n] = b;
`ifdef PRGA_ASCII_CHECK_EN
      if (b < 'h20 || b > 'h7E) m_valid = 1'b0;
`endif
    end
    m_cyc = 3 + 9 * e;
    m_swr = 2 * e;
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) img_s[a] = 8'(a);
  endtask

  task automatic load_mems();
    @(negedge clk) mem_load = 1'b1;
    @(negedge clk) mem_load = 1'b0;
  endtask

  // Pulse en for one cycle, then count cycles from leaving READY until rdy returns.
  task automatic run_a(output int cyc);
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    chk("rdy_drop", 32'(bus.rdy), 32'd0);
    cyc = 0;
    while (bus.rdy !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_vs_model(input string tag, input int cyc);
    chk({tag, "_cycles"}, 32'(cyc), 32'(m_cyc));
    chk({tag, "_swr"}, 32'(s_wr_cnt), 32'(m_swr));
    chk({tag, "_pt_valid"}, 32'(bus.pt_valid), 32'(m_valid));
    for (int a = 0; a < 256; a++) begin
      chk($sformatf("%s_pt[%0d]", tag, a), 32'(pt_mem[a]), 32'(m_pt[a]));
      chk($sformatf("%s_s[%0d]", tag, a), 32'(s_mem[a]), 32'(m_s[a]));
    end
  endtask

  typedef struct {
    logic [7:0] ct[4];
    logic [7:0] pt[4];
    int         cyc;
    int         swr;
    bit         asc_ok;
  } vec_t;

  vec_t vt[5];

  initial begin
    int cyc;
    bit exp_valid;

    vt[0] = '{ct: '{8'h03, 8'h41, 8'h42, 8'h43}, pt: '{8'h03, 8'h43, 8'h47, 8'h44}, cyc: 30, swr: 6, asc_ok: 1'b1};
    vt[1] = '{ct: '{8'h00, 8'h41, 8'h42, 8'h43}, pt: '{8'h00, 8'hEE, 8'hEE, 8'hEE}, cyc: 3,  swr: 0, asc_ok: 1'b1};
    vt[2] = '{ct: '{8'h01, 8'h02, 8'h00, 8'h00}, pt: '{8'h01, 8'h00, 8'hEE, 8'hEE}, cyc: 12, swr: 2, asc_ok: 1'b0};
    vt[3] = '{ct: '{8'h02, 8'h22, 8'h7B, 8'h00}, pt: '{8'h02, 8'h20, 8'h7E, 8'hEE}, cyc: 21, swr: 4, asc_ok: 1'b1};
    vt[4] = '{ct: '{8'h02, 8'h7D, 8'h42, 8'h00}, pt: '{8'h02, 8'h7F, 8'h47, 8'hEE}, cyc: 21, swr: 4, asc_ok: 1'b0};

    bus.en   = 1'b0;
    bus_b.en = 1'b0;
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
    set_identity();
    load_mems();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(bus.rdy), 32'd1);
    chk("rst_s_wren", 32'(bus.s_wren), 32'd0);
    chk("rst_pt_wren", 32'(bus.pt_wren), 32'd0);
    chk("rst_s_addr", 32'(bus.s_addr), 32'd0);
    chk("rst_ct_addr", 32'(bus.ct_addr), 32'd0);
    chk("rst_pt_addr", 32'(bus.pt_addr), 32'd0);
    chk("rst_pt_wrdata", 32'(bus.pt_wrdata), 32'd0);
    chk("rst_pt_valid", 32'(bus.pt_valid), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, identity S
    for (int v = 0; v < 5; v++) begin
      set_identity();
      for (int a = 0; a < 4; a++) ct_mem[a] = vt[v].ct[a];
      load_mems();
      model_run(255);
      run_a(cyc);
`ifdef PRGA_ASCII_CHECK_EN
      exp_valid = vt[v].asc_ok;
`else
      exp_valid = 1'b1;
`endif
      $display("run table %0d: len=%0d cycles=%0d pt=%h %h %h %h valid=%0b", v, vt[v].ct[0], cyc,
               pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3], bus.pt_valid);
      for (int a = 0; a < 4; a++)
        chk($sformatf("tab%0d_pt[%0d]", v, a), 32'(pt_mem[a]), 32'(vt[v].pt[a]));
      chk($sformatf("tab%0d_cycles", v), 32'(cyc), 32'(vt[v].cyc));
      chk($sformatf("tab%0d_swr", v), 32'(s_wr_cnt), 32'(vt[v].swr));
      chk($sformatf("tab%0d_valid", v), 32'(bus.pt_valid), 32'(exp_valid));
      if (v == 0) begin
        chk("tab0_s2", 32'(s_mem[2]), 32'h03);
        chk("tab0_s3", 32'(s_mem[3]), 32'h05);
        chk("tab0_s5", 32'(s_mem[5]), 32'h02);
        chk("tab0_s4", 32'(s_mem[4]), 32'h04);
      end
      check_vs_model($sformatf("tab%0d", v), cyc);
    end

    // Randomized permutations and ciphertexts
    for (int r = 0; r < 8; r++) begin
      set_identity();
      for (int a = 255; a > 0; a--) begin
        int x;
        logic [7:0] t;
        x = $urandom_range(a, 0);
        t = img_s[a]; img_s[a] = img_s[x]; img_s[x] = t;
      end
      ct_mem[0] = 8'($urandom_range(24, 1));
      for (int a = 1; a < 256; a++) ct_mem[a] = 8'($urandom);
      load_mems();
      model_run(255);
      run_a(cyc);
      $display("run random %0d: len=%0d cycles=%0d", r, ct_mem[0], cyc);
      check_vs_model($sformatf("rnd%0d", r), cyc);
    end

    // en held high for a whole run: no restart until rdy=1
    set_identity();
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
    ct_mem[0] = 8'h03; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42; ct_mem[3] = 8'h43;
    load_mems();
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk);
    chk("hold_rdy_drop", 32'(bus.rdy), 32'd0);
    cyc = 0;
    while (bus.rdy !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    bus.en = 1'b0;
    $display("run en_held: cycles=%0d pt_writes=%0d", cyc, pt_wr_cnt);
    chk("hold_cycles", 32'(cyc), 32'd30);
    chk("hold_pt_writes", 32'(pt_wr_cnt), 32'd4);
    repeat (5) @(negedge clk);
    chk("hold_idle_rdy", 32'(bus.rdy), 32'd1);
    chk("hold_idle_pt_writes", 32'(pt_wr_cnt), 32'd4);

    // en pulses while busy are ignored
    load_mems();
    model_run(255);
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    cyc = 0;
    while (bus.rdy !== 1'b1 && cyc < LIMIT) begin
      bus.en = ((cyc % 5) == 2);
      @(negedge clk);
      cyc++;
    end
    bus.en = 1'b0;
    $display("run en_pulses: cycles=%0d pt_writes=%0d", cyc, pt_wr_cnt);
    chk("pulse_pt_writes", 32'(pt_wr_cnt), 32'd4);
    check_vs_model("pulse", cyc);

    // Reset during WR_I of byte 2
    load_mems();
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    cyc = 0;
    while (!(bus.s_wren === 1'b1 && bus.s_addr === 8'd2) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_wr_i2_cycle", 32'(cyc), 32'd16);
    #1 rst_n = 1'b0;
    #1;
    $display("run mid_reset: asserted at cycle %0d", cyc);
    chk("mid_rdy", 32'(bus.rdy), 32'd1);
    chk("mid_s_wren", 32'(bus.s_wren), 32'd0);
    chk("mid_pt_wren", 32'(bus.pt_wren), 32'd0);
    chk("mid_s_addr", 32'(bus.s_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_s_writes", 32'(s_wr_cnt), 32'd2);
    chk("mid_pt_writes", 32'(pt_wr_cnt), 32'd2);
    chk("mid_pt1", 32'(pt_mem[1]), 32'h43);
    chk("mid_pt2", 32'(pt_mem[2]), 32'hEE);
    chk("mid_s2", 32'(s_mem[2]), 32'h02);
    // Fresh run after reset must start from i=j=0 and reread ct[0]
    load_mems();
    model_run(255);
    run_a(cyc);
    $display("run after_reset: cycles=%0d pt=%h %h %h %h", cyc, pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]);
    chk("post_pt0", 32'(pt_mem[0]), 32'h03);
    chk("post_pt3", 32'(pt_mem[3]), 32'h44);
    check_vs_model("post", cyc);

    // MAX_LEN=2 instance: only two bytes processed
    load_mems();
    model_run(2);
    @(negedge clk) bus_b.en = 1'b1;
    @(negedge clk) bus_b.en = 1'b0;
    cyc = 0;
    while (bus_b.rdy !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    $display("run max_len2: cycles=%0d pt=%h %h %h %h", cyc, pt_mem_b[0], pt_mem_b[1], pt_mem_b[2], pt_mem_b[3]);
    chk("ml2_cycles", 32'(cyc), 32'd21);
    chk("ml2_pt0", 32'(pt_mem_b[0]), 32'h02);
    chk("ml2_pt1", 32'(pt_mem_b[1]), 32'h43);
    chk("ml2_pt2", 32'(pt_mem_b[2]), 32'h47);
    chk("ml2_pt3", 32'(pt_mem_b[3]), 32'hEE);
    chk("ml2_pt_writes", 32'(pt_wr_cnt_b), 32'd3);
    for (int a = 0; a < 256; a++)
      chk($sformatf("ml2_s[%0d]", a), 32'(s_mem_b[a]), 32'(m_s[a]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
